conv_mac_serial: RTL and testbench
==================================

# conv_mac_serial

Serial multiply-accumulate stage that sits directly downstream of the X/F vector shift-register memories in the convolution engine. It captures one window of `TAPS` signed X samples and `TAPS` signed filter coefficients, computes their dot product one tap per cycle into a widened accumulator, and saturates the result to `WIDTH` bits. The result is offered on a valid/ready output port. A one-cycle `x_consume` pulse at capture tells the controller that the X memory may shift to the next window.

## Interface
- `WIDTH`, 16: bit width of samples, coefficients and result (signed two's complement).
- `TAPS`, 8: number of window taps processed per output. Legal range is 2 to the X memory depth + 1.
- `LOGTAPS`, 3: ceil(log2(`TAPS`)); width of the tap counter.

- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `x_taps` input `WIDTH` x [`TAPS`-1:0], signed: current X window, taken from the parallel X memory outputs, with index 0 as the oldest sample.
- `f_taps` input `WIDTH` x [`TAPS`-1:0], signed: filter coefficients from the F memory.
- `start` input 1: request to process the window currently on `x_taps`/`f_taps`.
- `in_ready` output 1: block can accept `start`.
- `x_consume` output 1: one-cycle pulse on the cycle after a window is accepted.
- `y_out` output `WIDTH`, signed: saturated dot-product result.
- `out_valid` output 1: `y_out` holds a result.
- `out_ready` input 1: downstream accepts `y_out`.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - MAC: `in_ready`=0.
  - DONE: `in_ready`=0, `out_valid`=1.
- `in_ready` is a combinational decode of state==IDLE.
- IDLE → MAC when `start` is high at a rising edge:
  - Register all `x_taps` and `f_taps` into internal capture registers.
  - Clear the accumulator and clear tap counter `k`.
  - Pulse `x_consume` high for the following cycle.
- `start` while not in IDLE is ignored and has no side effects.
- MAC: each cycle, add sign-extended product `xcap[k]*fcap[k]` to the accumulator, then increment `k`.
  - After the update with `k`=`TAPS`-1, go to DONE and load `y_out` with the saturated accumulator.
- Arithmetic widths:
  - Each product is 2·`WIDTH` bits.
  - The accumulator is 2·`WIDTH`+`LOGTAPS` bits, so no intermediate overflow is possible.
- Saturation of the final accumulator value A:
  - A > 2^(`WIDTH`-1)-1 → `y_out` = 2^(`WIDTH`-1)-1.
  - A < -2^(`WIDTH`-1) → `y_out` = -2^(`WIDTH`-1).
  - Otherwise `y_out` = A[`WIDTH`-1:0].
- DONE:
  - `y_out` is held stable while `out_valid`=1 and `out_ready`=0.
  - On `out_valid`&&`out_ready`, go to IDLE. `out_valid` falls the next cycle; `y_out` keeps its last value.
- Capture registers decouple the block from the X memory, so the memory may shift during MAC without affecting the result.

## Timing
- Reset (`reset_n` low, asynchronous, at any time including mid-MAC or DONE):
  - state=IDLE, `k`=0, accumulator=0.
  - `y_out`=0, `out_valid`=0, `x_consume`=0.
  - `in_ready`=1.
  - A pending result is discarded.
- Cycle 0: `start` sampled high in IDLE.
- Cycle 1: `x_consume`=1, `in_ready`=0, first MAC update (k=0).
- Cycle `TAPS`: last MAC update (k=`TAPS`-1).
- Cycle `TAPS`+1: `out_valid`=1 and `y_out` valid. Latency from `start` to `out_valid` is `TAPS`+1 cycles.
- If `out_ready` is high in cycle `TAPS`+1, `in_ready`=1 in cycle `TAPS`+2. The next `start` can be accepted then.
  - Minimum initiation interval is `TAPS`+2 cycles.
- `out_ready` may toggle arbitrarily. `out_valid` never drops without a handshake, except on reset.
- `x_consume` is exactly one cycle wide per accepted window. It never asserts for an ignored `start`.

## Test plan
- Unit window: `TAPS`=8, all x=1, all f=1, pulse `start` → `x_consume` at cycle 1, `out_valid` at cycle 9, `y_out`=8.
- Index order: x[i]=i+1 for i=0..7; f[3]=1, all other f=0 → `y_out`=4. Then f[i]=i, all x=1 → `y_out`=28.
- Saturation:
  - x=32767 and f=32767 on all taps → `y_out`=32767.
  - x=-32768 and f=32767 → `y_out`=-32768.
  - x=-3 and f=5 → `y_out`=-120.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`, and pulse `start` during that time →
  - `y_out` stays stable and `in_ready` stays 0.
  - The `start` is ignored and no `x_consume` is produced.
  - Raising `out_ready` completes the handshake, and `in_ready` returns to 1 one cycle later.
- Capture isolation: change `x_taps`/`f_taps` every cycle during MAC → result equals the dot product of the values present at cycle 0.
- Reset and throughput:
  - Assert `reset_n` low at cycle 4 of MAC → `out_valid`=0, `y_out`=0, `in_ready`=1. The next window computes correctly.
  - With `out_ready` tied high and `start` held high, results appear every 10 cycles.

Source files
------------

// File: rtl/conv_mac_serial.sv
// Serial dot-product MAC: captures a TAPS-wide X/F window, accumulates one
// tap per cycle into a widened accumulator, saturates and offers the result.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   x_taps, f_taps        : window samples / coefficients (index 0 = oldest)
//   start, in_ready       : window request / block is idle
//   x_consume             : one-cycle pulse after a window is accepted
//   y_out, out_valid      : saturated result and its valid flag
//   out_ready             : downstream accepts y_out
module conv_mac_serial #(
   parameter int WIDTH   = 16,
   parameter int TAPS    = 8,
   parameter int LOGTAPS = 3
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [TAPS-1:0][WIDTH-1:0]   x_taps,
   input  logic [TAPS-1:0][WIDTH-1:0]   f_taps,
   input  logic                         start,
   output logic                         in_ready,
   output logic                         x_consume,
   output logic signed [WIDTH-1:0]      y_out,
   output logic                         out_valid,
   input  logic                         out_ready
);

   localparam int PW = 2 * WIDTH;
   localparam int AW = 2 * WIDTH + LOGTAPS;

   localparam logic signed [AW-1:0] SAT_MAX =
      {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN =
      {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [TAPS-1:0][WIDTH-1:0] xcap_q;
   logic [TAPS-1:0][WIDTH-1:0] fcap_q;
   logic [LOGTAPS-1:0]         k_q;
   logic signed [AW-1:0]       acc_q;
   logic signed [AW-1:0]       acc_d;
   logic signed [WIDTH-1:0]    y_q;
   logic signed [WIDTH-1:0]    y_sat;
   logic                       xcons_q;

   logic signed [WIDTH-1:0]    xk;
   logic signed [WIDTH-1:0]    fk;
   logic signed [PW-1:0]       prod;
   logic                       accept;
   logic                       last;

   assign accept = (state_q == S_IDLE) && start;
   assign last   = (k_q == LOGTAPS'(TAPS - 1));

   // Datapath: one signed product per cycle, sign-extended into the
   // accumulator; saturation is applied to the value being written.
   always_comb begin
      xk    = xcap_q[k_q];
      fk    = fcap_q[k_q];
      prod  = xk * fk;
      acc_d = acc_q + {{LOGTAPS{prod[PW-1]}}, prod};
      if (acc_d > SAT_MAX) begin
         y_sat = SAT_MAX[WIDTH-1:0];
      end else if (acc_d < SAT_MIN) begin
         y_sat = SAT_MIN[WIDTH-1:0];
      end else begin
         y_sat = acc_d[WIDTH-1:0];
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (start) begin
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            if (last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         xcap_q  <= '0;
         fcap_q  <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         y_q     <= '0;
         xcons_q <= 1'b0;
      end else begin
         state_q <= state_d;
         xcons_q <= accept;
         if (accept) begin
            xcap_q <= x_taps;
            fcap_q <= f_taps;
            k_q    <= '0;
            acc_q  <= '0;
         end else if (state_q == S_MAC) begin
            acc_q <= acc_d;
            k_q   <= k_q + 1'b1;
            if (last) begin
               y_q <= y_sat;
            end
         end
      end
   end

   assign x_consume = xcons_q;
   assign y_out     = y_q;

endmodule

// File: tb/tb_conv_mac_serial.sv
// Testbench for conv_mac_serial: cycle-level reference model plus
// directed windows with hand-computed results.
module tb_conv_mac_serial;

   localparam int WIDTH   = 16;
   localparam int TAPS    = 8;
   localparam int LOGTAPS = 3;

   logic                       clk;
   logic                       reset_n;
   logic [TAPS-1:0][WIDTH-1:0] x_taps;
   logic [TAPS-1:0][WIDTH-1:0] f_taps;
   logic                       start;
   logic                       in_ready;
   logic                       x_consume;
   logic signed [WIDTH-1:0]    y_out;
   logic                       out_valid;
   logic                       out_ready;

   int checks = 0;
   int errors = 0;

   conv_mac_serial #(
      .WIDTH  (WIDTH),
      .TAPS   (TAPS),
      .LOGTAPS(LOGTAPS)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .x_taps   (x_taps),
      .f_taps   (f_taps),
      .start    (start),
      .in_ready (in_ready),
      .x_consume(x_consume),
      .y_out    (y_out),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: saturated dot product computed with plain integers.
   function automatic longint ref_dot(input logic [TAPS-1:0][WIDTH-1:0] xv,
                                      input logic [TAPS-1:0][WIDTH-1:0] fv);
      longint s = 0;
      longint a;
      longint b;
      for (int i = 0; i < TAPS; i++) begin
         a = longint'($signed(xv[i]));
         b = longint'($signed(fv[i]));
         s += a * b;
      end
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   // Transaction-level model: a window accepted while idle produces its
   // result TAPS+1 cycles later and stays offered until a handshake.
   bit     m_ready = 1'b1;
   bit     m_busy  = 1'b0;
   bit     m_valid = 1'b0;
   bit     m_cons  = 1'b0;
   int     m_cnt   = 0;
   longint m_res   = 0;
   longint m_y     = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_ready = 1'b1;
         m_busy  = 1'b0;
         m_valid = 1'b0;
         m_cons  = 1'b0;
         m_cnt   = 0;
         m_y     = 0;
      end else begin
         bit acc;
         bit hs;
         acc = m_ready && start;
         hs  = m_valid && out_ready;
         if (m_busy) begin
            m_cnt++;
            if (m_cnt == TAPS) begin
               m_busy  = 1'b0;
               m_valid = 1'b1;
               m_y     = m_res;
            end
         end
         if (hs) begin
            m_valid = 1'b0;
            m_ready = 1'b1;
         end
         m_cons = acc;
         if (acc) begin
            m_ready = 1'b0;
            m_busy  = 1'b1;
            m_cnt   = 0;
            m_res   = ref_dot(x_taps, f_taps);
         end
      end
   end

   bit run_cmp = 1'b0;

   always @(posedge clk) begin
      #2;
      if (run_cmp) begin
         chk("m_in_ready", longint'(in_ready), longint'(m_ready));
         chk("m_out_valid", longint'(out_valid), longint'(m_valid));
         chk("m_x_consume", longint'(x_consume), longint'(m_cons));
         chk("m_y_out", longint'(y_out), m_y);
      end
   end

   task automatic set_all(input int xv, input int fv);
      for (int i = 0; i < TAPS; i++) begin
         x_taps[i] = WIDTH'(xv);
         f_taps[i] = WIDTH'(fv);
      end
   endtask

   // Pulse start, check x_consume at cycle 1 and out_valid at cycle TAPS+1.
   task automatic run_window(input string name, input int exp_y);
      int n;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({name, "_xcons"}, longint'(x_consume), 1);
      n = 1;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_lat"}, n, TAPS + 1);
      chk({name, "_y"}, longint'(y_out), exp_y);
      @(negedge clk);
      chk({name, "_rdy"}, longint'(in_ready), 1);
   endtask

   initial begin
      int q[$];
      int n;
      logic signed [WIDTH-1:0] y_hold;
      logic prev_v;

      reset_n   = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      set_all(0, 0);
      repeat (2) @(negedge clk);
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_y", longint'(y_out), 0);
      chk("rst_xcons", longint'(x_consume), 0);
      reset_n = 1'b1;
      run_cmp = 1'b1;
      @(negedge clk);

      set_all(1, 1);
      run_window("unit", 8);

      set_all(0, 0);
      for (int i = 0; i < TAPS; i++) x_taps[i] = WIDTH'(i + 1);
      f_taps[3] = 16'd1;
      run_window("idx_f3", 4);

      set_all(1, 0);
      for (int i = 0; i < TAPS; i++) f_taps[i] = WIDTH'(i);
      run_window("idx_ramp", 28);

      set_all(32767, 32767);
      run_window("sat_pos", 32767);
      set_all(-32768, 32767);
      run_window("sat_neg", -32768);
      set_all(-3, 5);
      run_window("neg_small", -120);

      // Backpressure with an ignored start while the result is held.
      set_all(2, 3);
      out_ready = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_lat", n, TAPS + 1);
      y_hold = y_out;
      chk("bp_y", longint'(y_out), 48);
      for (int c = 0; c < 5; c++) begin
         start = (c == 1);
         @(negedge clk);
         chk("bp_y_stable", longint'(y_out), longint'(y_hold));
         chk("bp_in_ready", longint'(in_ready), 0);
         chk("bp_valid", longint'(out_valid), 1);
         chk("bp_xcons", longint'(x_consume), 0);
      end
      start = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", longint'(in_ready), 1);

      // Inputs scrambled during MAC must not affect the captured window.
      for (int i = 0; i < TAPS; i++) begin
         x_taps[i] = WIDTH'(i + 1);
         f_taps[i] = WIDTH'(i + 1);
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         for (int i = 0; i < TAPS; i++) begin
            x_taps[i] = WIDTH'($urandom);
            f_taps[i] = WIDTH'($urandom);
         end
         @(negedge clk);
         n++;
      end
      chk("iso_y", longint'(y_out), 204);
      @(negedge clk);

      // Reset in the middle of MAC discards the window.
      set_all(4, 4);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", longint'(out_valid), 0);
      chk("mid_rst_y", longint'(y_out), 0);
      chk("mid_rst_rdy", longint'(in_ready), 1);
      @(negedge clk);
      reset_n = 1'b1;
      set_all(1, 1);
      run_window("post_rst", 8);

      // Back-to-back throughput with start held high.
      set_all(-1, 7);
      start  = 1'b1;
      prev_v = out_valid;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid && !prev_v) q.push_back(c);
         prev_v = out_valid;
      end
      start = 1'b0;
      chk("tp_count", q.size() >= 3, 1);
      for (int i = 1; i < q.size(); i++) begin
         chk("tp_period", q[i] - q[i-1], TAPS + 2);
      end
      chk("tp_y", longint'(y_out), -56);
      n = 0;
      while (!in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("tp_drain", longint'(in_ready), 1);
      repeat (2) @(negedge clk);

      run_cmp = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
